// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU func codes, issuer FSM encoding and default widths.
//   No ports; imported by alu_regfile and alu_issuer.
package alu_pkg;
  localparam int OPCODE_SIZE = 3;
  localparam int DATA_SIZE = 8;
  localparam logic [2:0] FUNC_ADD   = 3'b000;
  localparam logic [2:0] FUNC_ADD2  = 3'b001;
  localparam logic [2:0] FUNC_MUL   = 3'b010;
  localparam logic [2:0] FUNC_AND   = 3'b011;
  localparam logic [2:0] FUNC_OR    = 3'b100;
  localparam logic [2:0] FUNC_XOR   = 3'b101;
  localparam logic [2:0] FUNC_XNOR  = 3'b110;
  localparam logic [2:0] FUNC_XNOR2 = 3'b111;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 2-read/1-write register file, synchronously cleared on rst.
//   clk, rst          clock, sync active-high clear
//   we, waddr, wdata  write port
//   raddr1/rdata1, raddr2/rdata2  combinational read ports
module alu_regfile #(
  parameter int addr_w = 3,
  parameter int data_w = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [data_w-1:0] wdata,
  input  logic [addr_w-1:0] raddr1,
  input  logic [addr_w-1:0] raddr2,
  output logic [data_w-1:0] rdata1,
  output logic [data_w-1:0] rdata2
);
  logic [data_w-1:0] mem [2**addr_w];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 2**addr_w; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: issues register-file commands to a registered ALU and returns results.
//   cmd_*        valid/ready command in (load immediate or ALU op)
//   alu_*        drive/receive the external ALU (alu_result = ALU dataOut)
//   rsp_*        valid/ready response out
//   mismatch     sticky self-check error; built only with ALU_ISSUER_CHECK_EN
module alu_issuer import alu_pkg::*; #(
  parameter int opcodeSize  = OPCODE_SIZE,
  parameter int dataSize    = DATA_SIZE,
  parameter int regAddrSize = 3,
  parameter int aluLatency  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_load,
  input  logic [opcodeSize-1:0]  cmd_func,
  input  logic [regAddrSize-1:0] cmd_dst,
  input  logic [regAddrSize-1:0] cmd_src1,
  input  logic [regAddrSize-1:0] cmd_src2,
  input  logic [dataSize-1:0]    cmd_imm,
  output logic [opcodeSize-1:0]  alu_func,
  output logic [dataSize-1:0]    alu_data1,
  output logic [dataSize-1:0]    alu_data2,
  input  logic [dataSize-1:0]    alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [dataSize-1:0]    rsp_data,
  output logic                   mismatch
);
  // WAIT leaves when cnt hits 0, so it is loaded with latency-2 to spend latency-1 cycles there
  localparam int cnt_w = aluLatency > 2 ? $clog2(aluLatency - 1) : 1;
  localparam logic [cnt_w-1:0] cnt_init = cnt_w'(aluLatency > 1 ? aluLatency - 2 : 0);
  state_t state, next;
  logic [regAddrSize-1:0] dst, waddr;
  logic [dataSize-1:0] rd1, rd2, wdata;
  logic [cnt_w-1:0] cnt;
  logic accept, we;
  assign cmd_ready = state == IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign rsp_valid = state == RESP;
  assign we = (accept && cmd_load) || state == CAPTURE;
  assign waddr = state == CAPTURE ? dst : cmd_dst;
  assign wdata = state == CAPTURE ? alu_result : cmd_imm;
  alu_regfile #(.addr_w(regAddrSize), .data_w(dataSize)) u_rf (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(cmd_src1), .raddr2(cmd_src2), .rdata1(rd1), .rdata2(rd2)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? (cmd_load ? RESP : ISSUE) : IDLE;
      ISSUE:   next = aluLatency == 1 ? CAPTURE : WAIT;
      WAIT:    next = cnt == '0 ? CAPTURE : WAIT;
      CAPTURE: next = RESP;
      RESP:    next = rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      alu_func <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      dst <= '0;
      cnt <= '0;
      rsp_data <= '0;
    end else begin
      state <= next;
      if (accept && !cmd_load) begin
        alu_func <= cmd_func;
        alu_data1 <= rd1;
        alu_data2 <= rd2;
        dst <= cmd_dst;
      end
      if (state == ISSUE) cnt <= cnt_init;
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (we) rsp_data <= wdata;
    end
`ifdef ALU_ISSUER_CHECK_EN
  localparam int half = dataSize / 2;
  logic [dataSize-1:0] expected;
  always_comb begin
    expected = ~(alu_data1 ^ alu_data2);
    case (alu_func)
      FUNC_ADD:  expected = alu_data1 + alu_data2;
      FUNC_ADD2: expected = alu_data1 + alu_data2 + dataSize'(2);
      FUNC_MUL:  expected = dataSize'(alu_data1[half-1:0]) * dataSize'(alu_data2[half-1:0]);
      FUNC_AND:  expected = alu_data1 & alu_data2;
      FUNC_OR:   expected = alu_data1 | alu_data2;
      FUNC_XOR:  expected = alu_data1 ^ alu_data2;
      default:   expected = ~(alu_data1 ^ alu_data2);
    endcase
  end
  always_ff @(posedge clk)
    if (rst) mismatch <= 1'b0;
    else if (state == CAPTURE && alu_result != expected) mismatch <= 1'b1;
`else
  assign mismatch = 1'b0;
`endif
endmodule
